hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage RV32 core; successor to the single-penalty control unit.
- Detects load-use hazards and holds IF/ID for a configurable number of cycles.
- Arbitrates EX (conditional) versus ID (unconditional) redirects to IF, and squashes EX for a configurable branch penalty.
- Freezes the front end while a multi-cycle EX unit is busy.
- Exposes saturating stall and flush performance counters.

Parameters:
XLEN, 32, datapath/PC width
REG_AW, 5, register index width
LOAD_STALL, 1, load-use stall/bubble cycles (1..3)
BR_FLUSH, 2, EX-squash cycles per EX redirect (1..3)
PERF_W, 32, performance counter width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID
id_rs1_vld, id_rs2_vld  in  1  source register actually read
ex_rd  in  REG_AW  rd of the instruction in the ID/EX register
ex_opcode  in  7  opcode of the instruction in the ID/EX register
ex_busy  in  1  multi-cycle EX unit (mul/div) not done
id_jmp_vld  in  1  unconditional jump decoded in ID
id_imm, id_pc  in  XLEN  jump offset and PC in ID
ex_jmp_vld  in  1  conditional branch taken in EX
ex_jmp_addr  in  XLEN  EX branch target
hold_if  out  1  freeze PC/IF
hold_id  out  1  freeze IF/ID register
if_jmp_vld  out  1  redirect IF
if_jmp_addr  out  XLEN  redirect target
ex_en  out  1  EX may commit its instruction
perf_stall  out  PERF_W  saturating count of hold_if cycles
perf_flush  out  PERF_W  saturating count of ex_en=0 cycles

Behaviour:
- Reset values: state RUN; all counters 0; ex_en=1; perf_* = 0. hold_if, hold_id, if_jmp_vld and if_jmp_addr are combinational and equal 0 while inputs are idle.
- lu_hit (combinational) = ex_opcode==7'b0000011 && ex_rd!=0 && ((id_rs1==ex_rd && id_rs1_vld) || (id_rs2==ex_rd && id_rs2_vld)). Writes to x0 never stall.
- FSM states:
  - RUN: if ex_jmp_vld, stay RUN. Else if ex_busy, go to BUSY. Else if lu_hit, go to LU (stall_cnt <= LOAD_STALL-1, bub_cnt <= LOAD_STALL).
  - LU: stall_cnt decrements; return to RUN when it reaches 0. lu_hit is ignored in LU.
  - BUSY: stay while ex_busy; on its fall go to RUN. lu_hit is re-evaluated in RUN on the next cycle.
- hold_if = hold_id = (RUN && lu_hit && !ex_jmp_vld && !ex_busy) || (LU && stall_cnt!=0) || ex_busy. Under the default, a load-use hazard gives exactly 1 hold cycle (the detect cycle).
- Bubble: bub_cnt loads on entry to LU. Decrement each cycle while nonzero. EX is squashed for LOAD_STALL cycles starting at detect+1.
- Redirect mux, combinational, priority ex_jmp_vld > id_jmp_vld > none:
  - addr = ex_jmp_addr, or (id_pc+id_imm) mod 2^XLEN, or 0.
  - id_jmp_vld is also ignored while hold_id=1.
- Flush: on ex_jmp_vld, fl_cnt <= BR_FLUSH-1.
  - fl_cnt decrements while nonzero.
  - A new ex_jmp_vld while counting reloads fl_cnt, so penalties do not accumulate.
- ex_jmp_vld in LU:
  - forces state to RUN and clears stall_cnt and bub_cnt (the stalled instruction is younger and flushed);
  - drops hold_if in that same cycle.
- ex_en = !(ex_jmp_vld || fl_cnt!=0 || bub_cnt!=0). ex_busy does not clear ex_en.
- perf_stall increments on hold_if=1; perf_flush increments on ex_en=0. Both saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-flush clears everything in the same cycle, asynchronously.

Decomposition:
- Shared package/defines: LOAD opcode 7'b0000011, FSM state encodings (RUN/LU/BUSY), counter width clog2(4).
- One natural sub-module: hazard_perf_cnt, a saturating PERF_W counter with an inc input, instantiated twice.

Test Plan:
1. Defaults; ex_opcode=LOAD, ex_rd=5, id_rs1=5, rs1_vld=1 -> hold_if=1 for 1 cycle; ex_en=0 on the next cycle only; perf_stall=1, perf_flush=1.
2. Same hazard with ex_rd=0, or rs1_vld=0 -> no hold, ex_en stays 1.
3. LOAD_STALL=3 -> hold_if high 3 cycles from detect; ex_en low cycles detect+1..detect+3.
4. ex_jmp_vld=1, ex_jmp_addr=0x80 together with id_jmp_vld=1, id_pc=0x10, id_imm=0x20 -> if_jmp_addr=0x80; ex_en low 2 cycles. id_jmp alone -> addr 0x30, ex_en stays 1. id_pc=0xFFFFFFF0, id_imm=0x20 -> 0x10 (wrap).
5. Back-to-back ex_jmp_vld on cycles 0 and 1 (BR_FLUSH=2) -> ex_en low cycles 0-2 only. ex_jmp during LU with LOAD_STALL=3 -> hold_if drops that cycle, bubbles cancelled.
6. ex_busy high 4 cycles with lu_hit present -> hold_if high 4 cycles, ex_en=1 throughout; the load-use stall starts after busy falls. Assert rst mid-sequence -> all counters 0 immediately.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes,
// FSM state encoding and the width of the small penalty counters.
package hazard_ctrl_pkg;

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  // Wide enough for penalties of 1..3 cycles
  localparam int CNT_W = $clog2(4);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LU   = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for the stall/flush performance statistics.
module hazard_perf_cnt #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [PERF_W-1:0] cnt
);

  // Sticks at all-ones so a long run never reports a small wrapped value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + PERF_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 core: load-use stalls, redirect
// arbitration, branch squash, multi-cycle EX freeze and perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int BR_FLUSH   = 2,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_vld,
  input  logic              id_rs2_vld,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [6:0]        ex_opcode,
  input  logic              ex_busy,
  input  logic              id_jmp_vld,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              ex_jmp_vld,
  input  logic [XLEN-1:0]   ex_jmp_addr,
  output logic              hold_if,
  output logic              hold_id,
  output logic              if_jmp_vld,
  output logic [XLEN-1:0]   if_jmp_addr,
  output logic              ex_en,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_flush
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] stall_cnt, stall_nxt;
  logic [CNT_W-1:0] bub_cnt, bub_nxt;
  logic [CNT_W-1:0] fl_cnt, fl_nxt;
  logic             lu_hit;
  logic             lu_detect;
  logic             hold;
  logic             id_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      stall_cnt <= '0;
      bub_cnt   <= '0;
      fl_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_nxt;
      bub_cnt   <= bub_nxt;
      fl_cnt    <= fl_nxt;
    end
  end

  // A taken EX branch outranks everything: the stalled instruction is younger
  // and gets flushed, so its stall and bubbles are cancelled at once.
  always_comb begin
    lu_hit = (ex_opcode == OP_LOAD) && (ex_rd != '0) &&
             (((id_rs1 == ex_rd) && id_rs1_vld) || ((id_rs2 == ex_rd) && id_rs2_vld));
    lu_detect = (state == ST_RUN) && lu_hit && !ex_jmp_vld && !ex_busy;
    hold = lu_detect || ((state == ST_LU) && (stall_cnt != '0) && !ex_jmp_vld) || ex_busy;

    state_nxt = state;
    stall_nxt = stall_cnt;
    case (state)
      ST_RUN: begin
        if (!ex_jmp_vld) begin
          if (ex_busy) begin
            state_nxt = ST_BUSY;
          end else if (lu_hit) begin
            state_nxt = ST_LU;
            stall_nxt = CNT_W'(LOAD_STALL - 1);
          end
        end
      end
      ST_LU: begin
        if (ex_jmp_vld || (stall_cnt == '0)) begin
          state_nxt = ST_RUN;
          stall_nxt = '0;
        end else begin
          stall_nxt = stall_cnt - CNT_W'(1);
        end
      end
      ST_BUSY: begin
        if (!ex_busy) state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
        stall_nxt = '0;
      end
    endcase

    bub_nxt = bub_cnt;
    if (lu_detect) begin
      bub_nxt = CNT_W'(LOAD_STALL);
    end else if ((state == ST_LU) && ex_jmp_vld) begin
      bub_nxt = '0;
    end else if (bub_cnt != '0) begin
      bub_nxt = bub_cnt - CNT_W'(1);
    end

    fl_nxt = fl_cnt;
    if (ex_jmp_vld) begin
      fl_nxt = CNT_W'(BR_FLUSH - 1);
    end else if (fl_cnt != '0) begin
      fl_nxt = fl_cnt - CNT_W'(1);
    end
  end

  // A held ID stage must not redirect fetch, otherwise the jump would fire twice
  always_comb begin
    hold_if     = hold;
    hold_id     = hold;
    id_take     = id_jmp_vld && !hold;
    if_jmp_vld  = ex_jmp_vld || id_take;
    if_jmp_addr = '0;
    if (ex_jmp_vld) begin
      if_jmp_addr = ex_jmp_addr;
    end else if (id_take) begin
      if_jmp_addr = id_pc + id_imm;
    end
    ex_en = !(ex_jmp_vld || (fl_cnt != '0) || (bub_cnt != '0));
  end

  hazard_perf_cnt #(.PERF_W(PERF_W)) u_perf_stall (
    .clk (clk),
    .rst (rst),
    .inc (hold),
    .cnt (perf_stall)
  );

  hazard_perf_cnt #(.PERF_W(PERF_W)) u_perf_flush (
    .clk (clk),
    .rst (rst),
    .inc (!ex_en),
    .cnt (perf_flush)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a default instance and a LOAD_STALL=3/BR_FLUSH=3/4-bit
// perf instance share stimulus and are compared to a remaining-cycles model.
module tb_hazard_ctrl;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        clk, rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_vld, id_rs2_vld;
  logic [6:0]  ex_opcode;
  logic        ex_busy, id_jmp_vld, ex_jmp_vld;
  logic [31:0] id_imm, id_pc, ex_jmp_addr;

  logic        hold_if_a, hold_id_a, if_jmp_vld_a, ex_en_a;
  logic [31:0] if_jmp_addr_a, perf_stall_a, perf_flush_a;
  logic        hold_if_b, hold_id_b, if_jmp_vld_b, ex_en_b;
  logic [31:0] if_jmp_addr_b;
  logic [3:0]  perf_stall_b, perf_flush_b;

  hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_vld(id_rs1_vld), .id_rs2_vld(id_rs2_vld), .ex_rd(ex_rd),
    .ex_opcode(ex_opcode), .ex_busy(ex_busy), .id_jmp_vld(id_jmp_vld),
    .id_imm(id_imm), .id_pc(id_pc), .ex_jmp_vld(ex_jmp_vld),
    .ex_jmp_addr(ex_jmp_addr), .hold_if(hold_if_a), .hold_id(hold_id_a),
    .if_jmp_vld(if_jmp_vld_a), .if_jmp_addr(if_jmp_addr_a), .ex_en(ex_en_a),
    .perf_stall(perf_stall_a), .perf_flush(perf_flush_a)
  );

  hazard_ctrl #(.LOAD_STALL(3), .BR_FLUSH(3), .PERF_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_vld(id_rs1_vld), .id_rs2_vld(id_rs2_vld), .ex_rd(ex_rd),
    .ex_opcode(ex_opcode), .ex_busy(ex_busy), .id_jmp_vld(id_jmp_vld),
    .id_imm(id_imm), .id_pc(id_pc), .ex_jmp_vld(ex_jmp_vld),
    .ex_jmp_addr(ex_jmp_addr), .hold_if(hold_if_b), .hold_id(hold_id_b),
    .if_jmp_vld(if_jmp_vld_b), .if_jmp_addr(if_jmp_addr_b), .ex_en(ex_en_b),
    .perf_stall(perf_stall_b), .perf_flush(perf_flush_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: per instance, cycles left in the load-use window, bubbles and
  // squash cycles still owed, whether a busy freeze is in progress, perf totals.
  int     lu_left[2], bub_left[2], fl_left[2];
  bit     busy_mode[2];
  longint pst[2], pfl[2];
  bit     e_det[2], e_hold[2], e_en[2], e_jv[2];
  logic [31:0] e_ja[2];

  function automatic int lsOf(input int i);
    return (i == 0) ? 1 : 3;
  endfunction
  function automatic int bfOf(input int i);
    return (i == 0) ? 2 : 3;
  endfunction
  function automatic longint pmaxOf(input int i);
    return (i == 0) ? 64'hFFFF_FFFF : 64'd15;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      lu_left[i] = 0; bub_left[i] = 0; fl_left[i] = 0;
      busy_mode[i] = 1'b0; pst[i] = 0; pfl[i] = 0;
    end
  endtask

  task automatic computeExp();
    bit lu_hit;
    bit id_take;
    logic [31:0] tgt;
    lu_hit = (ex_opcode == OP_LOAD) && (ex_rd != 0) &&
             (((id_rs1 == ex_rd) && id_rs1_vld) || ((id_rs2 == ex_rd) && id_rs2_vld));
    tgt = id_pc + id_imm;
    for (int i = 0; i < 2; i++) begin
      e_det[i]  = (lu_left[i] == 0) && !busy_mode[i] && lu_hit && !ex_jmp_vld && !ex_busy;
      e_hold[i] = e_det[i] || ((lu_left[i] > 1) && !ex_jmp_vld) || ex_busy;
      e_en[i]   = !(ex_jmp_vld || (fl_left[i] > 0) || (bub_left[i] > 0));
      id_take   = id_jmp_vld && !e_hold[i];
      e_jv[i]   = ex_jmp_vld || id_take;
      e_ja[i]   = ex_jmp_vld ? ex_jmp_addr : (id_take ? tgt : 32'h0);
    end
  endtask

  task automatic modelStep();
    for (int i = 0; i < 2; i++) begin
      if (e_hold[i] && (pst[i] < pmaxOf(i))) pst[i]++;
      if (!e_en[i] && (pfl[i] < pmaxOf(i))) pfl[i]++;
      if (lu_left[i] > 0) begin
        if (ex_jmp_vld) begin
          lu_left[i] = 0; bub_left[i] = 0;
        end else begin
          lu_left[i]--;
          if (bub_left[i] > 0) bub_left[i]--;
        end
      end else begin
        if (bub_left[i] > 0) bub_left[i]--;
        if (busy_mode[i]) busy_mode[i] = ex_busy;
        else if (e_det[i]) begin
          lu_left[i] = lsOf(i); bub_left[i] = lsOf(i);
        end else if (!ex_jmp_vld && ex_busy) busy_mode[i] = 1'b1;
      end
      if (ex_jmp_vld) fl_left[i] = bfOf(i) - 1;
      else if (fl_left[i] > 0) fl_left[i]--;
    end
  endtask

  task automatic checkNow(input string tag);
    #1;
    computeExp();
    checkOutput({tag, ".hold_if_a"}, 32'(hold_if_a), 32'(e_hold[0]));
    checkOutput({tag, ".hold_id_a"}, 32'(hold_id_a), 32'(e_hold[0]));
    checkOutput({tag, ".jv_a"}, 32'(if_jmp_vld_a), 32'(e_jv[0]));
    checkOutput({tag, ".ja_a"}, if_jmp_addr_a, e_ja[0]);
    checkOutput({tag, ".ex_en_a"}, 32'(ex_en_a), 32'(e_en[0]));
    checkOutput({tag, ".pst_a"}, perf_stall_a, 32'(pst[0]));
    checkOutput({tag, ".pfl_a"}, perf_flush_a, 32'(pfl[0]));
    checkOutput({tag, ".hold_if_b"}, 32'(hold_if_b), 32'(e_hold[1]));
    checkOutput({tag, ".hold_id_b"}, 32'(hold_id_b), 32'(e_hold[1]));
    checkOutput({tag, ".jv_b"}, 32'(if_jmp_vld_b), 32'(e_jv[1]));
    checkOutput({tag, ".ja_b"}, if_jmp_addr_b, e_ja[1]);
    checkOutput({tag, ".ex_en_b"}, 32'(ex_en_b), 32'(e_en[1]));
    checkOutput({tag, ".pst_b"}, 32'(perf_stall_b), 32'(pst[1]));
    checkOutput({tag, ".pfl_b"}, 32'(perf_flush_b), 32'(pfl[1]));
  endtask

  task automatic advance();
    modelStep();
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    checkNow(tag);
    advance();
  endtask

  task automatic setIdle();
    id_rs1 = '0; id_rs2 = '0; id_rs1_vld = 1'b0; id_rs2_vld = 1'b0;
    ex_rd = '0; ex_opcode = OP_ALU; ex_busy = 1'b0;
    id_jmp_vld = 1'b0; id_imm = '0; id_pc = '0;
    ex_jmp_vld = 1'b0; ex_jmp_addr = '0;
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic rs1v, input logic [4:0] rd,
                               input logic [6:0] op, input logic busy);
    setIdle();
    id_rs1 = rs1; id_rs1_vld = rs1v; ex_rd = rd; ex_opcode = op; ex_busy = busy;
  endtask

  task automatic applyJumps(input logic ej, input logic [31:0] ea, input logic ij,
                            input logic [31:0] pc, input logic [31:0] imm);
    ex_jmp_vld = ej; ex_jmp_addr = ea; id_jmp_vld = ij; id_pc = pc; id_imm = imm;
  endtask

  task automatic randomStimulus();
    id_rs1 = 5'($urandom_range(0, 3));
    id_rs2 = 5'($urandom_range(0, 3));
    id_rs1_vld = 1'($urandom);
    id_rs2_vld = 1'($urandom);
    ex_rd = 5'($urandom_range(0, 3));
    ex_opcode = ($urandom_range(0, 1) == 1) ? OP_LOAD : OP_ALU;
    if (ex_busy) ex_busy = ($urandom_range(0, 9) < 7);
    else ex_busy = ($urandom_range(0, 9) == 0);
    ex_jmp_vld = ($urandom_range(0, 7) == 0);
    ex_jmp_addr = $urandom;
    id_jmp_vld = ($urandom_range(0, 3) == 0);
    id_pc = $urandom;
    id_imm = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    setIdle();
    modelReset();
    #2;
    checkOutput("rst.hold_if", 32'(hold_if_a), 32'h0);
    checkOutput("rst.jv", 32'(if_jmp_vld_a), 32'h0);
    checkOutput("rst.ja", if_jmp_addr_a, 32'h0);
    checkOutput("rst.ex_en", 32'(ex_en_a), 32'h1);
    checkOutput("rst.pst", perf_stall_a, 32'h0);
    checkOutput("rst.pfl_b", 32'(perf_flush_b), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Load-use hazard on rs1, one cycle of hazard inputs
    applyStimulus(5'd5, 1'b1, 5'd5, OP_LOAD, 1'b0);
    checkNow("lu1");
    checkOutput("lu1.hold_const", 32'(hold_if_a), 32'h1);
    advance();
    setIdle();
    checkNow("lu1+1");
    checkOutput("lu1+1.en_const", 32'(ex_en_a), 32'h0);
    checkOutput("lu1+1.holdb_const", 32'(hold_if_b), 32'h1);
    advance();
    for (int k = 0; k < 3; k++) step("lu1tail");
    checkOutput("lu1.pst_const", perf_stall_a, 32'd1);
    checkOutput("lu1.pfl_const", perf_flush_a, 32'd1);
    checkOutput("lu1.pstb_const", 32'(perf_stall_b), 32'd3);
    checkOutput("lu1.pflb_const", 32'(perf_flush_b), 32'd3);

    // x0 destination and unread source never stall
    applyStimulus(5'd0, 1'b1, 5'd0, OP_LOAD, 1'b0);
    step("x0");
    applyStimulus(5'd5, 1'b0, 5'd5, OP_LOAD, 1'b0);
    step("novld");
    setIdle();
    step("idle");

    // Redirect priority, ID-only target and address wrap
    setIdle();
    applyJumps(1'b1, 32'h80, 1'b1, 32'h10, 32'h20);
    checkNow("jmp_ex");
    checkOutput("jmp_ex.addr_const", if_jmp_addr_a, 32'h80);
    advance();
    setIdle();
    applyJumps(1'b0, 32'h0, 1'b1, 32'h10, 32'h20);
    checkNow("jmp_id");
    checkOutput("jmp_id.addr_const", if_jmp_addr_a, 32'h30);
    advance();
    applyJumps(1'b0, 32'h0, 1'b1, 32'hFFFF_FFF0, 32'h20);
    checkNow("jmp_wrap");
    checkOutput("jmp_wrap.addr_const", if_jmp_addr_a, 32'h10);
    advance();
    setIdle();
    for (int k = 0; k < 3; k++) step("jmp_tail");

    // Back-to-back EX redirects do not stack their penalties
    applyJumps(1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
    step("b2b0");
    step("b2b1");
    setIdle();
    checkNow("b2b2");
    checkOutput("b2b2.en_const", 32'(ex_en_a), 32'h0);
    advance();
    checkNow("b2b3");
    checkOutput("b2b3.en_const", 32'(ex_en_a), 32'h1);
    advance();
    for (int k = 0; k < 3; k++) step("b2b_tail");

    // EX redirect arriving during a long load-use window
    applyStimulus(5'd7, 1'b1, 5'd7, OP_LOAD, 1'b0);
    step("lujmp0");
    setIdle();
    applyJumps(1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
    checkNow("lujmp1");
    checkOutput("lujmp1.holdb_const", 32'(hold_if_b), 32'h0);
    advance();
    setIdle();
    for (int k = 0; k < 4; k++) step("lujmp_tail");

    // Busy EX with a pending hazard: the stall follows the freeze
    for (int k = 0; k < 4; k++) begin
      applyStimulus(5'd3, 1'b1, 5'd3, OP_LOAD, 1'b1);
      step("busy");
    end
    applyStimulus(5'd3, 1'b1, 5'd3, OP_LOAD, 1'b0);
    for (int k = 0; k < 2; k++) step("busy_fall");
    setIdle();
    for (int k = 0; k < 4; k++) step("busy_tail");

    // Asynchronous reset in the middle of a stall and a squash
    applyStimulus(5'd2, 1'b1, 5'd2, OP_LOAD, 1'b0);
    step("mr0");
    setIdle();
    applyJumps(1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
    step("mr1");
    setIdle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mrst.pst", perf_stall_a, 32'h0);
    checkOutput("mrst.pfl", perf_flush_a, 32'h0);
    checkOutput("mrst.ex_en_b", 32'(ex_en_b), 32'h1);
    checkOutput("mrst.hold_b", 32'(hold_if_b), 32'h0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      randomStimulus();
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
